// File: rtl/screen_sequencer.sv
// Screen sequencer: blanked NEXT/PREV/JUMP/BACK navigation between screens.
// Define SCREEN_HISTORY_EN for a HIST_DEPTH-deep BACK stack instead of a toggle.
module screen_sequencer #(
  parameter int NUM_SCREENS  = 4,
  parameter int IDX_W        = 2,
  parameter int TRANS_FRAMES = 8,
  parameter int WRAP         = 0,
  parameter int HIST_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_target,
  output logic [IDX_W-1:0] screen,
  output logic             blank,
  output logic             screen_changed,
  output logic             cmd_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUT,
    S_SWITCH,
    S_BIN
  } state_t;

  localparam logic [1:0] OP_NEXT = 2'd0;
  localparam logic [1:0] OP_PREV = 2'd1;
  localparam logic [1:0] OP_JUMP = 2'd2;
  localparam logic [1:0] OP_BACK = 2'd3;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SCREENS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   NS   = (IDX_W + 1)'(NUM_SCREENS);
  localparam logic [7:0] TF_LAST =
    (TRANS_FRAMES == 0) ? 8'd0 : 8'(TRANS_FRAMES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] screen_q, screen_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic             blank_q, blank_d;
  logic             chg_q, chg_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] dest;
  logic             legal;
  logic             tick_done;
  logic             hist_vld;
  logic [IDX_W-1:0] hist_top;

`ifdef SCREEN_HISTORY_EN
  localparam int HC_W = $clog2(HIST_DEPTH + 1);
  localparam logic [HC_W-1:0] HFULL = HC_W'(HIST_DEPTH);

  logic [IDX_W-1:0] hist_q [HIST_DEPTH];
  logic [IDX_W-1:0] hist_d [HIST_DEPTH];
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic             back_q, back_d;

  assign hist_vld = (hcnt_q != '0);
  assign hist_top = hist_q[0];
`else
  logic [IDX_W-1:0] prev_q, prev_d;
  logic             pvld_q, pvld_d;
  logic             unused_cfg;

  assign hist_vld   = pvld_q;
  assign hist_top   = prev_q;
  assign unused_cfg = ^HIST_DEPTH;
`endif

  assign cmd_ready      = (state_q == S_IDLE);
  assign screen         = screen_q;
  assign blank          = blank_q;
  assign screen_changed = chg_q;
  assign cmd_error      = err_q;

  // Destination and legality of the offered command
  always_comb begin
    dest  = screen_q;
    legal = 1'b0;
    unique case (cmd_op)
      OP_NEXT: begin
        if (screen_q == LAST) begin
          legal = (WRAP != 0);
          dest  = '0;
        end else begin
          legal = 1'b1;
          dest  = screen_q + ONE;
        end
      end
      OP_PREV: begin
        if (screen_q == '0) begin
          legal = (WRAP != 0);
          dest  = LAST;
        end else begin
          legal = 1'b1;
          dest  = screen_q - ONE;
        end
      end
      OP_JUMP: begin
        legal = ({1'b0, cmd_target} < NS);
        dest  = cmd_target;
      end
      OP_BACK: begin
        legal = hist_vld;
        dest  = hist_top;
      end
      default: ;
    endcase
  end

  assign tick_done = (TRANS_FRAMES == 0) ||
                     (frame_tick && (cnt_q == TF_LAST));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    screen_d = screen_q;
    dest_d   = dest_q;
    blank_d  = blank_q;
    chg_d    = 1'b0;
    err_d    = 1'b0;
`ifdef SCREEN_HISTORY_EN
    hist_d   = hist_q;
    hcnt_d   = hcnt_q;
    back_d   = back_q;
`else
    prev_d   = prev_q;
    pvld_d   = pvld_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (dest != screen_q) begin
            state_d = S_BOUT;
            blank_d = 1'b1;
            cnt_d   = '0;
            dest_d  = dest;
`ifdef SCREEN_HISTORY_EN
            back_d  = (cmd_op == OP_BACK);
`endif
          end
        end
      end
      S_BOUT: begin
        if (tick_done) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SWITCH: begin
        state_d  = S_BIN;
        cnt_d    = '0;
        screen_d = dest_q;
        chg_d    = 1'b1;
`ifdef SCREEN_HISTORY_EN
        if (back_q) begin
          for (int i = 0; i < HIST_DEPTH - 1; i++)
            hist_d[i] = hist_q[i+1];
          hist_d[HIST_DEPTH-1] = '0;
          hcnt_d = hcnt_q - 1'b1;
        end else begin
          // Full stack shifts the oldest entry out the bottom
          for (int i = 1; i < HIST_DEPTH; i++)
            hist_d[i] = hist_q[i-1];
          hist_d[0] = screen_q;
          if (hcnt_q != HFULL)
            hcnt_d = hcnt_q + 1'b1;
        end
`else
        prev_d = screen_q;
        pvld_d = 1'b1;
`endif
      end
      S_BIN: begin
        if (tick_done) begin
          state_d = S_IDLE;
          blank_d = 1'b0;
          cnt_d   = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      screen_q <= '0;
      dest_q   <= '0;
      blank_q  <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SCREEN_HISTORY_EN
      for (int i = 0; i < HIST_DEPTH; i++)
        hist_q[i] <= '0;
      hcnt_q   <= '0;
      back_q   <= 1'b0;
`else
      prev_q   <= '0;
      pvld_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      screen_q <= screen_d;
      dest_q   <= dest_d;
      blank_q  <= blank_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
`ifdef SCREEN_HISTORY_EN
      hist_q   <= hist_d;
      hcnt_q   <= hcnt_d;
      back_q   <= back_d;
`else
      prev_q   <= prev_d;
      pvld_q   <= pvld_d;
`endif
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: dut0 WRAP=0, dut1 WRAP=1, both TRANS_FRAMES=2.
// Reference keeps current screen and history as plain ints / arrays.
module tb_screen_sequencer;

  localparam int NS = 4;
  localparam int IW = 3;
  localparam int TF = 2;
  localparam int HD = 4;

  logic clk = 1'b0;
  logic rst;
  logic tick [2];
  logic cv [2];
  logic rdy [2];
  logic blank [2];
  logic chg [2];
  logic err [2];
  logic [1:0] op [2];
  logic [IW-1:0] tgt [2];
  logic [IW-1:0] scr [2];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_scr [2];
  int hstk [2][HD];
  int hn [2];
  int prev [2];
  bit pv [2];

  always #5 clk = ~clk;

  screen_sequencer #(
    .NUM_SCREENS(NS), .IDX_W(IW), .TRANS_FRAMES(TF),
    .WRAP(0), .HIST_DEPTH(HD)
  ) u_dut0 (
    .clk(clk), .rst(rst), .frame_tick(tick[0]),
    .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_op(op[0]), .cmd_target(tgt[0]),
    .screen(scr[0]), .blank(blank[0]),
    .screen_changed(chg[0]), .cmd_error(err[0])
  );

  screen_sequencer #(
    .NUM_SCREENS(NS), .IDX_W(IW), .TRANS_FRAMES(TF),
    .WRAP(1), .HIST_DEPTH(HD)
  ) u_dut1 (
    .clk(clk), .rst(rst), .frame_tick(tick[1]),
    .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_op(op[1]), .cmd_target(tgt[1]),
    .screen(scr[1]), .blank(blank[1]),
    .screen_changed(chg[1]), .cmd_error(err[1])
  );

  // {screen, blank, cmd_ready, screen_changed, cmd_error}
  function automatic logic [6:0] obs(int d);
    return {scr[d], blank[d], rdy[d], chg[d], err[d]};
  endfunction

  function automatic logic [6:0] expv(int s, bit b, bit r,
                                      bit c, bit e);
    return {IW'(s), b, r, c, e};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_scr[d] = 0;
      hn[d]    = 0;
      prev[d]  = 0;
      pv[d]    = 1'b0;
      for (int i = 0; i < HD; i++) hstk[d][i] = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; tick[d] = 1'b0;
      op[d] = 2'd0; tgt[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Issue one command in IDLE and follow it to completion.
  task automatic do_cmd(int d, int o, int t);
    int old, dst, phase, n;
    bit legal, done, justsw;
    logic [6:0] e;
    old = m_scr[d];
    dst = old;
    legal = 1'b0;
    case (o)
      0: begin
        if (old == NS - 1) begin legal = (d == 1); dst = 0; end
        else begin legal = 1'b1; dst = old + 1; end
      end
      1: begin
        if (old == 0) begin legal = (d == 1); dst = NS - 1; end
        else begin legal = 1'b1; dst = old - 1; end
      end
      2: begin legal = (t < NS); dst = t; end
      default: begin
`ifdef SCREEN_HISTORY_EN
        legal = (hn[d] > 0);
        dst = hstk[d][0];
`else
        legal = pv[d];
        dst = prev[d];
`endif
      end
    endcase

    e = expv(old, 0, 1, 0, 0);
    vectors++;
    if (obs(d) !== e) begin
      miscompares++;
      $display("FAIL idle_pre dut%0d op%0d: got %b expected %b",
               d, o, obs(d), e);
    end
    cv[d] = 1'b1; op[d] = 2'(o); tgt[d] = IW'(t);
    tick[d] = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    cv[d] = 1'b0;

    if (!legal) begin
      e = expv(old, 0, 1, 0, 1);
      vectors++;
      if (obs(d) !== e) begin
        miscompares++;
        $display("FAIL illegal_pulse dut%0d op%0d: got %b expected %b",
                 d, o, obs(d), e);
      end
      tick[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      tick[d] = 1'b0;
      e = expv(old, 0, 1, 0, 0);
      vectors++;
      if (obs(d) !== e) begin
        miscompares++;
        $display("FAIL illegal_after dut%0d op%0d: got %b expected %b",
                 d, o, obs(d), e);
      end
    end else if (dst == old) begin
      tick[d] = 1'b0;
      e = expv(old, 0, 1, 0, 0);
      vectors++;
      if (obs(d) !== e) begin
        miscompares++;
        $display("FAIL noop dut%0d op%0d: got %b expected %b",
                 d, o, obs(d), e);
      end
    end else begin
      phase = 0; n = 0; done = 1'b0; justsw = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        if (phase < 2) e = expv(old, 1, 0, 0, 0);
        else e = expv(dst, 1, 0, justsw, 0);
        vectors++;
        if (obs(d) !== e) begin
          miscompares++;
          $display("FAIL transition dut%0d cyc%0d: got %b expected %b",
                   d, cyc, obs(d), e);
        end
        tick[d] = 1'($urandom_range(0, 1));
        cv[d]   = 1'($urandom_range(0, 1));
        op[d]   = 2'($urandom_range(0, 3));
        tgt[d]  = IW'($urandom_range(0, 7));
        @(posedge clk);
        if (phase == 0) begin
          if (tick[d]) n++;
          if (n == TF) phase = 1;
        end else if (phase == 1) begin
          phase = 2; n = 0; justsw = 1'b1;
        end else begin
          justsw = 1'b0;
          if (tick[d]) n++;
          if (n == TF) done = 1'b1;
        end
        @(negedge clk);
        cv[d] = 1'b0;
      end
      tick[d] = 1'b0;
      if (!done) begin
        miscompares++;
        $display("FAIL timeout dut%0d: transition never finished", d);
      end
      e = expv(dst, 0, 1, 0, 0);
      vectors++;
      if (obs(d) !== e) begin
        miscompares++;
        $display("FAIL transition_end dut%0d: got %b expected %b",
                 d, obs(d), e);
      end
      m_scr[d] = dst;
`ifdef SCREEN_HISTORY_EN
      if (o == 3) begin
        for (int i = 0; i < HD - 1; i++) hstk[d][i] = hstk[d][i+1];
        hn[d]--;
      end else begin
        for (int i = HD - 1; i > 0; i--) hstk[d][i] = hstk[d][i-1];
        hstk[d][0] = old;
        if (hn[d] < HD) hn[d]++;
      end
`else
      prev[d] = old;
      pv[d] = 1'b1;
`endif
    end
  endtask

  task automatic test_reset();
    logic [6:0] e;
    @(negedge clk);
    rst = 1'b1;
    #1;
    e = expv(0, 0, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs(d) !== e) begin
        miscompares++;
        $display("FAIL reset_held dut%0d: got %b expected %b",
                 d, obs(d), e);
      end
    end
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== e) begin
          miscompares++;
          $display("FAIL reset_release dut%0d c%0d: got %b expected %b",
                   d, c, obs(d), e);
        end
      end
    end
  endtask

  task automatic test_next();
    apply_reset();
    do_cmd(0, 0, 0);
    vectors++;
    if (scr[0] !== IW'(1)) begin
      miscompares++;
      $display("FAIL next_screen: got %0d expected 1", scr[0]);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    do_cmd(0, 2, 5);
    do_cmd(0, 1, 0);
    do_cmd(0, 2, 7);
    do_cmd(1, 1, 0);
    vectors++;
    if (scr[1] !== IW'(3)) begin
      miscompares++;
      $display("FAIL wrap_prev: got %0d expected 3", scr[1]);
    end
    do_cmd(1, 0, 0);
  endtask

  task automatic test_noop();
    apply_reset();
    do_cmd(0, 2, 0);
    do_cmd(0, 2, 3);
    do_cmd(0, 2, 3);
  endtask

  task automatic test_history();
    apply_reset();
    do_cmd(0, 2, 2);
    do_cmd(0, 2, 3);
    do_cmd(0, 3, 0);
    vectors++;
    if (scr[0] !== IW'(2)) begin
      miscompares++;
      $display("FAIL back1: got %0d expected 2", scr[0]);
    end
    do_cmd(0, 3, 0);
    do_cmd(0, 3, 0);
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    bit seen;
    apply_reset();
    @(negedge clk);
    cv[0] = 1'b1; op[0] = 2'd2; tgt[0] = IW'(2);
    @(negedge clk);
    cv[0] = 1'b0;
    tick[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (scr[0] === IW'(2)) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_reach: screen %0d never reached 2", scr[0]);
    end
    @(negedge clk);
    tick[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    e = expv(0, 0, 1, 0, 0);
    vectors++;
    if (obs(0) !== e) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b expected %b", obs(0), e);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs(0) !== e) begin
        miscompares++;
        $display("FAIL mid_reset_hold: got %b expected %b", obs(0), e);
      end
    end
    rst = 1'b0;
    model_reset();
    do_cmd(0, 3, 0);
  endtask

  task automatic test_back_to_back();
    int d;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
      d = ($urandom_range(0, 3) == 0) ? 1 : 0;
      do_cmd(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; tick[d] = 1'b0;
      op[d] = 2'd0; tgt[d] = '0;
    end
    model_reset();
    test_reset();
    test_next();
    test_illegal();
    test_noop();
    test_history();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
